// File: rtl/pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_gen_pkg
// Description : Shared definitions for the packet generator. Provides the FSM
//               state encoding, the 16-bit LFSR taps with its seed and step
//               functions, header field offset helpers and the word byte
//               count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_gen_pkg;

  // Default geometry, used as the parameter defaults of pkt_gen
  localparam int DEF_DW    = 32;
  localparam int DEF_DA_W  = 4;
  localparam int DEF_PRI_W = 3;
  localparam int DEF_LEN_W = 10;
  localparam int DEF_GAP_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOP  = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_EOP  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  // Feedback taps: s[15] ^ s[13] ^ s[12] ^ s[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Seed from the header low byte; the two halves are complements of each
  // other, so the seed can never be all zeros.
  function automatic logic [15:0] lfsr_seed(input logic [7:0] hdr_lo);
    return {~hdr_lo, hdr_lo};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Header layout is {len, prior, da} with da in the LSBs
  function automatic int hdr_pri_lsb(input int da_w);
    return da_w;
  endfunction

  function automatic int hdr_len_lsb(input int da_w, input int pri_w);
    return da_w + pri_w;
  endfunction

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : pkt_lfsr16
// Description : 16-bit Fibonacci LFSR for LFSR-mode payload words.
//               Load takes priority over advance.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               i_load      - load i_seed into the state
//               i_seed      - seed value
//               i_adv       - shift the state once
//               o_state     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_lfsr16
  import pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_state <= '0;
    end else if (i_load) begin
      o_state <= i_seed;
    end else if (i_adv) begin
      o_state <= lfsr_step(o_state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : pkt_gen
// Description : Parametrised packet generator. Emits sop, a header word,
//               ceil(len/bytes) payload words (LFSR or incrementing bytes,
//               last-word lanes beyond len zeroed), then eop, honouring
//               downstream backpressure, followed by a programmable idle gap.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               i_da/i_prior/i_len    - header fields, captured on accept
//               i_mode                - 0 LFSR payload, 1 incrementing bytes
//               i_gap                 - idle cycles after eop
//               i_gen_vld/o_gen_ready - request handshake
//               i_ready               - downstream accepts current beat
//               o_sop/o_vld/o_eop     - beat strobes, o_data - beat word
//               o_busy                - generator not idle
//               o_pkt_cnt             - completed packets, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DA_W  = DEF_DA_W,
  parameter int PRI_W = DEF_PRI_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DA_W-1:0]  i_da,
  input  logic [PRI_W-1:0] i_prior,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_mode,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_gen_vld,
  output logic             o_gen_ready,
  input  logic             i_ready,
  output logic             o_sop,
  output logic             o_vld,
  output logic [DW-1:0]    o_data,
  output logic             o_eop,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam int BYTES   = bytes_per_word(DW);
  localparam int PRI_LSB = hdr_pri_lsb(DA_W);
  localparam int LEN_LSB = hdr_len_lsb(DA_W, PRI_W);
  // One extra bit so the running byte offset never overflows at max length
  localparam int BCNT_W  = LEN_W + 1;

  state_t             state;
  state_t             state_next;
  logic [DA_W-1:0]    da_r;
  logic [PRI_W-1:0]   prior_r;
  logic [LEN_W-1:0]   len_r;
  logic               mode_r;
  logic [GAP_W-1:0]   gap_r;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BCNT_W-1:0]  byte_cnt;   // byte offset of the word on o_data
  logic [BCNT_W-1:0]  byte_end;
  logic [BCNT_W-1:0]  word_off;   // byte offset of the next word to present
  logic               last_word;
  logic               accept;
  logic               beat_done;
  logic [DW-1:0]      hdr_word;
  logic [DW-1:0]      payload;
  logic [DW-1:0]      data_next;
  logic [15:0]        lfsr_state;
  logic [15:0]        lfsr_nxt;

  assign accept    = i_gen_vld && (state == S_IDLE);
  assign beat_done = i_ready && (state inside {S_SOP, S_HDR, S_DATA, S_EOP});
  assign byte_end  = byte_cnt + BCNT_W'(BYTES);
  assign last_word = (byte_end >= {1'b0, len_r});
  assign word_off  = (state == S_DATA) ? byte_end : '0;

  assign o_gen_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);

  always_comb begin
    hdr_word = '0;
    hdr_word[DA_W-1:0]          = da_r;
    hdr_word[PRI_LSB +: PRI_W]  = prior_r;
    hdr_word[LEN_LSB +: LEN_W]  = len_r;
  end

  // The word presented after HDR uses the seed itself; each later word uses
  // the state one shift ahead, matching the register update on that beat.
  assign lfsr_nxt = (state == S_HDR) ? lfsr_seed(hdr_word[7:0])
                                     : lfsr_step(lfsr_state);

  pkt_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  ((state == S_HDR) && i_ready),
    .i_seed  (lfsr_seed(hdr_word[7:0])),
    .i_adv   ((state == S_DATA) && i_ready),
    .o_state (lfsr_state)
  );

  generate
    for (genvar j = 0; j < BYTES; j++) begin : g_lane
      logic [BCNT_W-1:0] idx;
      logic [7:0]        fill;
      assign idx  = word_off + BCNT_W'(j);
      assign fill = mode_r ? idx[7:0] : lfsr_nxt[8*(j%2) +: 8];
      assign payload[8*j +: 8] = (idx < {1'b0, len_r}) ? fill : 8'h00;
    end
  endgenerate

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_gen_vld) state_next = S_SOP;
      S_SOP:  if (i_ready) state_next = S_HDR;
      S_HDR:  if (i_ready) state_next = (len_r == '0) ? S_EOP : S_DATA;
      S_DATA: if (i_ready && last_word) state_next = S_EOP;
      S_EOP:  if (i_ready) state_next = (gap_r == '0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_cnt == GAP_W'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_next = '0;
    if (state_next == S_HDR) begin
      data_next = hdr_word;
    end else if (state_next == S_DATA) begin
      data_next = payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      da_r      <= '0;
      prior_r   <= '0;
      len_r     <= '0;
      mode_r    <= 1'b0;
      gap_r     <= '0;
      gap_cnt   <= '0;
      byte_cnt  <= '0;
      o_sop     <= 1'b0;
      o_vld     <= 1'b0;
      o_eop     <= 1'b0;
      o_data    <= '0;
      o_pkt_cnt <= '0;
    end else begin
      if (accept) begin
        da_r    <= i_da;
        prior_r <= i_prior;
        len_r   <= i_len;
        mode_r  <= i_mode;
        gap_r   <= i_gap;
      end

      // Output registers only move when a beat completes (or a packet
      // starts), so they hold stable under backpressure.
      if (accept || beat_done) begin
        o_sop  <= (state_next == S_SOP);
        o_vld  <= (state_next == S_HDR) || (state_next == S_DATA);
        o_eop  <= (state_next == S_EOP);
        o_data <= data_next;
      end

      if ((state == S_HDR) && i_ready) begin
        byte_cnt <= '0;
      end else if ((state == S_DATA) && i_ready) begin
        byte_cnt <= byte_end;
      end

      if ((state == S_EOP) && i_ready) begin
        gap_cnt   <= gap_r;
        o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
